// File: rtl/ytrace_pkg.sv
// Shared defaults, record geometry and FSM encoding for the ytrace capture buffer.
package ytrace_pkg;

    localparam int unsigned DEF_DEPTH = 64;
    localparam int unsigned DEF_DW    = 32;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned REC_W     = 3 * DEF_DW;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDrain,
        StDone
    } state_e;

    // Record is {ins, rd2, wb}, so it is always three fields wide.
    function automatic int unsigned rec_width(input int unsigned dw);
        return 3 * dw;
    endfunction

endpackage

// File: rtl/ytrace_mem.sv
// Trace record storage: one synchronous write port, one combinational read port.
module ytrace_mem #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: stale contents are never exposed because the reader is gated by level.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ytrace_buffer.sv
// Retired-instruction trace buffer: arms on cap_en, captures up to stop_count records,
// then drains them through a first-word fall-through ready/valid port.
module ytrace_buffer
    import ytrace_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned DW    = DEF_DW
) (
    input  logic                      clk,
    input  logic                      INT,
    input  logic                      cap_en,
    input  logic [CNT_W-1:0]          stop_count,
    input  logic                      sample,
    input  logic [DW-1:0]             ins,
    input  logic [DW-1:0]             rd2,
    input  logic [DW-1:0]             wb,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3*DW-1:0]           out_data,
    output logic                      done,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned RW = rec_width(DW);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    state_e           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] captured_q, captured_d;
    logic [CNT_W-1:0] stop_q, stop_d;
    logic             overflow_q, overflow_d;

    logic             mem_we;
    logic [RW-1:0]    mem_wdata;
    logic [RW-1:0]    mem_rdata;
    logic             valid;

    assign mem_wdata = {ins, rd2, wb};

    ytrace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (mem_wdata),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        captured_d = captured_q;
        stop_d     = stop_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        valid      = 1'b0;

        case (state_q)
            StIdle: begin
                if (cap_en && (stop_count != '0)) begin
                    stop_d     = stop_count;
                    captured_d = '0;
                    state_d    = StCapture;
                end
            end
            StCapture: begin
                if (sample) begin
                    captured_d = captured_q + CNT_W'(1);
                    if (level_q < FULL) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        level_d  = level_q + LW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                // Compare the incremented count so stop_count=255 ends on the 255th sample.
                if (!cap_en || (sample && (captured_q + CNT_W'(1) == stop_q))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                valid = (level_q != '0);
                if (valid && out_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    level_d  = level_q - LW'(1);
                end
                if (level_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!cap_en) begin
                    overflow_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (INT) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            captured_q <= '0;
            stop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            captured_q <= captured_d;
            stop_q     <= stop_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = valid;
    assign out_data  = valid ? mem_rdata : '0;
    assign done      = (state_q == StDone);
    assign overflow  = overflow_q;
    assign level     = level_q;

endmodule

// File: doc/ytrace_buffer.md
YTRACE_BUFFER -- requirements
Module: ytrace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of trace entries (power of 2).
REQ-002 SHALL have parameter DW, default 32, width of each traced field.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port INT, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port cap_en, input, 1, arm/hold capture; level-sensitive.
REQ-006 SHALL have port stop_count, input, 8, number of records to capture; sampled on arm.
REQ-007 SHALL have port sample, input, 1, current cycle carries a retired instruction.
REQ-008 SHALL have port ins, input, DW, retired instruction word from yChip.
REQ-009 SHALL have port rd2, input, DW, register-file read port 2 value from yChip.
REQ-010 SHALL have port wb, input, DW, write-back value from yChip.
REQ-011 SHALL have port out_valid, output, 1, out_data holds an unread record.
REQ-012 SHALL have port out_ready, input, 1, reader accepts out_data this cycle.
REQ-013 SHALL have port out_data, output, 3*DW, record {ins, rd2, wb}, ins in the MSBs.
REQ-014 SHALL have port done, output, 1, capture and drain complete.
REQ-015 SHALL have port overflow, output, 1, sticky: at least one record dropped.
REQ-016 SHALL have port level, output, $clog2(DEPTH)+1, entries currently stored.

Function
REQ-017 SHALL implement states IDLE, CAPTURE, DRAIN, DONE.
REQ-018 In IDLE, cap_en=1 with stop_count>0 SHALL latch stop_count and enter CAPTURE next cycle; stop_count=0 SHALL keep IDLE.
REQ-019 In CAPTURE, each cycle with sample=1 SHALL increment the captured counter and, if level<DEPTH, write {ins,rd2,wb} at wr_ptr and increment wr_ptr and level.
REQ-020 In CAPTURE, sample=1 with level==DEPTH SHALL drop the record, still count it, and set overflow.
REQ-021 CAPTURE SHALL go to DRAIN in the cycle after the captured counter reaches the latched stop_count.
REQ-022 cap_en=0 during CAPTURE SHALL enter DRAIN next cycle; a sample in that same cycle SHALL be stored.
REQ-023 out_valid SHALL be 1 only in DRAIN with level>0; out_data SHALL be the entry at rd_ptr (first-word fall-through, zero-cycle read latency).
REQ-024 A transfer SHALL occur when out_valid && out_ready: rd_ptr increments and level decrements.
REQ-025 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 DRAIN with level==0 SHALL enter DONE; done SHALL be 1 only in DONE.
REQ-027 DONE SHALL return to IDLE on the first cycle with cap_en=0; overflow SHALL clear on that transition.
REQ-028 wr_ptr and rd_ptr SHALL be log2(DEPTH) bits and wrap modulo DEPTH; level SHALL be one bit wider.
REQ-029 No writes SHALL occur outside CAPTURE, and no reads outside DRAIN; sample SHALL be ignored outside CAPTURE.
REQ-030 The captured counter SHALL be 8 bits; stop_count=255 SHALL be honoured exactly (no wrap before compare).

Reset
REQ-031 INT=1 SHALL, on the next rising edge, force IDLE, wr_ptr=rd_ptr=level=0, captured=0, overflow=0.
REQ-032 During and after reset, out_valid=0, done=0, overflow=0, level=0, and out_data=0.
REQ-033 Reset mid-CAPTURE or mid-DRAIN SHALL abandon stored records; they SHALL NOT become readable.
REQ-034 Storage array contents SHALL NOT need clearing on reset.

Structure
REQ-035 Package ytrace_pkg SHALL hold DEPTH/DW defaults, the record width constant, and the state enum.
REQ-036 Storage SHALL be one sub-module, ytrace_mem: 1 write port, 1 asynchronous read port, DEPTH x 3*DW.
REQ-037 Control (FSM, pointers, counters, flags) SHALL live in ytrace_buffer.

Verification
REQ-038 Basic run: cap_en=1, stop_count=43, sample=1 for 43 cycles with ins=k, rd2=k+1, wb=k+2 (k=0..42), out_ready=1 -> 43 records read in order, then done=1, overflow=0.
REQ-039 Backpressure: 4 records stored, out_ready toggles 1/0 each cycle -> each record read exactly once, out_data stable while stalled, level 4->0.
REQ-040 Overflow: DEPTH=64, stop_count=70, sample=1 continuously -> level=64, overflow=1, 64 records read (k=0..63), then done=1.
REQ-041 Abort: stop_count=20, cap_en drops after 5 samples with sample=1 in the drop cycle -> 6 records drained, done=1.
REQ-042 Wrap-around: two back-to-back runs of 40 records each (return to IDLE in between) -> second run reads correctly across pointer wrap at 64.
REQ-043 Reset mid-DRAIN with level=10: INT=1 for one cycle -> IDLE, level=0, out_valid=0, done=0.
